// File: rtl/clk_en_gen_frac.sv
// Multi-channel fractional clock-enable generator: each channel pulses at an
// average rate of clk * num/den using a modulo-den phase accumulator.
module clk_en_gen_frac #(
    parameter int NUM_CH    = 3,
    parameter int ACC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic                        clear,
    input  logic [NUM_CH*ACC_WIDTH-1:0] num,
    input  logic [NUM_CH*ACC_WIDTH-1:0] den,
    output logic [NUM_CH-1:0]           clk_en_out,
    output logic [NUM_CH*16-1:0]        pulse_cnt
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_WIDTH-1:0] num_i;
            logic [ACC_WIDTH-1:0] den_i;
            logic [ACC_WIDTH-1:0] acc_reg;
            logic [ACC_WIDTH-1:0] acc_next;
            logic                 pulse_reg;
            logic                 pulse_next;
            logic [15:0]          cnt_reg;
            logic [15:0]          cnt_next;
            // One extra bit so acc+num never wraps before the compare with den.
            logic [ACC_WIDTH:0]   sum;
            logic [ACC_WIDTH:0]   diff;

            assign num_i = num[gi*ACC_WIDTH +: ACC_WIDTH];
            assign den_i = den[gi*ACC_WIDTH +: ACC_WIDTH];
            assign sum   = {1'b0, acc_reg} + {1'b0, num_i};
            assign diff  = sum - {1'b0, den_i};

            always_comb begin
                acc_next   = acc_reg;
                pulse_next = 1'b0;
                if (clear) begin
                    acc_next = '0;
                end else if (!ch_en[gi]) begin
                    acc_next = acc_reg;
                end else if ((den_i == '0) || (num_i == '0)) begin
                    acc_next = acc_reg;
                end else if (num_i >= den_i) begin
                    acc_next   = '0;
                    pulse_next = 1'b1;
                end else if (acc_reg >= den_i) begin
                    // den was lowered below the current phase: resync at once.
                    acc_next   = '0;
                    pulse_next = 1'b1;
                end else if (sum >= {1'b0, den_i}) begin
                    acc_next   = diff[ACC_WIDTH-1:0];
                    pulse_next = 1'b1;
                end else begin
                    acc_next = sum[ACC_WIDTH-1:0];
                end
            end

            assign cnt_next = pulse_next ? cnt_reg + 16'd1 : cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    acc_reg   <= '0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    acc_reg   <= acc_next;
                    pulse_reg <= pulse_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign clk_en_out[gi]          = pulse_reg;
            assign pulse_cnt[gi*16 +: 16]  = cnt_reg;
        end
    endgenerate

endmodule
